// File: rtl/pulse_to_level_converter.sv
// Pulse stretcher: each accepted single-cycle event on pulse_in produces a
// level held high for HOLD_CYCLES cycles, optionally followed by a forced-low
// gap. Events that cannot be accepted are flagged (dropped) and counted in a
// saturating counter (drop_count).
module pulse_to_level_converter #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int RETRIGGER   = 1,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              level_out,
  output logic              busy,
  output logic              dropped,
  output logic [DROP_W-1:0] drop_count
);

  // Shared HOLD/GAP down-counter width: clog2(max(HOLD, GAP, 2)).
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_HG < 2) ? 2 : MAX_HG;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          drop_evt;

  // Next-state, counter and drop-event decode; clear overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drop_evt  = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pulse_in) begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (pulse_in && (RETRIGGER != 0)) begin
            cnt_nxt = HOLD_LOAD;
          end else begin
            drop_evt = pulse_in;
            if (cnt == '0) begin
              if (GAP_CYCLES > 0) begin
                state_nxt = S_GAP;
                cnt_nxt   = GAP_LOAD;
              end else begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
              end
            end else begin
              cnt_nxt = cnt - CW'(1);
            end
          end
        end
        S_GAP: begin
          drop_evt = pulse_in;
          if (cnt == '0) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and shared counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Drop flag and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped    <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      dropped    <= 1'b0;
      drop_count <= '0;
    end else begin
      dropped <= drop_evt;
      if (drop_evt && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  assign level_out = (state == S_HOLD);
  assign busy      = (state != S_IDLE);

endmodule
